// File: rtl/avalon_s_pkg.sv
// Shared types and constants for the Avalon standard decoder.
package avalon_s_pkg;

    // Decoder FSM states
    typedef enum logic [1:0] {
        AVN_IDLE   = 2'd0,
        AVN_ACCESS = 2'd1,
        AVN_DONE   = 2'd2,
        AVN_ERR    = 2'd3
    } avn_dec_state_t;

    // Read data returned for unmapped reads and timed-out reads
    localparam logic [31:0] AVN_ERR_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/avalon_s_addr_decode.sv
// Combinational base/mask window decode; the lowest-index hit wins.
module avalon_s_addr_decode #(
    parameter int ND = 2,
    parameter int AW = 32
) (
    input  logic [AW-1:0]         addr,
    input  logic [ND-1:0][AW-1:0] base,
    input  logic [ND-1:0][AW-1:0] mask,
    output logic [ND-1:0]         sel,
    output logic                  hit
);

    // Scan upward so the first matching window claims the access
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int i = 0; i < ND; i++) begin
            if (!hit && ((addr & mask[i]) == base[i])) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/avalon_s_decoder.sv
// Single-host to multi-device Avalon address decoder with a registered
// command stage. Optional access timeout: define AVN_DECODER_TIMEOUT_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for host read/write; latch command and decode
// ACCESS | strobe selected device until its waitrequest drops
// DONE   | host waitrequest low for one cycle (normal completion)
// ERR    | host waitrequest low for one cycle, decode_error pulse
module avalon_s_decoder
    import avalon_s_pkg::*;
#(
    parameter int                    ND       = 2,
    parameter int                    DW       = 32,
    parameter int                    AW       = 32,
    parameter logic [ND-1:0][AW-1:0] BASE     = '0,
    parameter logic [ND-1:0][AW-1:0] MASK     = '0,
    parameter logic [31:0]           ERR_DATA = AVN_ERR_DATA,
    parameter int                    TMO_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_avn_read,
    input  logic                  host_avn_write,
    input  logic [AW-1:0]         host_avn_address,
    input  logic [DW/8-1:0]       host_avn_byte_enable,
    input  logic [DW-1:0]         host_avn_writedata,
    output logic [DW-1:0]         host_avn_readdata,
    output logic                  host_avn_waitrequest,
    output logic [ND-1:0]         devices_avn_read,
    output logic [ND-1:0]         devices_avn_write,
    output logic [AW-1:0]         devices_avn_address,
    output logic [DW/8-1:0]       devices_avn_byte_enable,
    output logic [DW-1:0]         devices_avn_writedata,
    input  logic [ND-1:0][DW-1:0] devices_avn_readdata,
    input  logic [ND-1:0]         devices_avn_waitrequest,
    output logic                  decode_error
);

    localparam logic [DW-1:0] ERR_DATA_W = DW'(ERR_DATA);

    if (DW % 8 != 0) begin : g_dw_check
        $error("avalon_s_decoder: DW must be a multiple of 8");
    end
    if (TMO_W < 2) begin : g_tmo_check
        $error("avalon_s_decoder: TMO_W must be at least 2");
    end

    avn_dec_state_t  state;
    logic            cmd_read;
    logic [ND-1:0]   sel_q;
    logic [ND-1:0]   dec_sel;
    logic            dec_hit;
    logic [DW-1:0]   dev_rdata;
    logic            dev_wait;

`ifdef AVN_DECODER_TIMEOUT_EN
    // Abort on the cycle the counter would step onto all-ones
    localparam logic [TMO_W-1:0] TMO_LAST = ~(TMO_W'(1));
    logic [TMO_W-1:0] tmo_cnt;
`endif

    avalon_s_addr_decode #(
        .ND (ND),
        .AW (AW)
    ) u_addr_decode (
        .addr (host_avn_address),
        .base (BASE),
        .mask (MASK),
        .sel  (dec_sel),
        .hit  (dec_hit)
    );

    // Return path from the selected device only
    always_comb begin
        dev_rdata = '0;
        for (int i = 0; i < ND; i++) begin
            if (sel_q[i]) begin
                dev_rdata |= devices_avn_readdata[i];
            end
        end
        dev_wait = |(devices_avn_waitrequest & sel_q);
    end

    // Decoder FSM with registered host and device outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                   <= AVN_IDLE;
            cmd_read                <= 1'b0;
            sel_q                   <= '0;
            host_avn_readdata       <= '0;
            host_avn_waitrequest    <= 1'b1;
            devices_avn_read        <= '0;
            devices_avn_write       <= '0;
            devices_avn_address     <= '0;
            devices_avn_byte_enable <= '0;
            devices_avn_writedata   <= '0;
            decode_error            <= 1'b0;
`ifdef AVN_DECODER_TIMEOUT_EN
            tmo_cnt                 <= '0;
`endif
        end else begin
            decode_error <= 1'b0;
            case (state)
                AVN_IDLE: begin
                    host_avn_waitrequest <= 1'b1;
                    if (host_avn_read || host_avn_write) begin
                        devices_avn_address     <= host_avn_address;
                        devices_avn_byte_enable <= host_avn_byte_enable;
                        devices_avn_writedata   <= host_avn_writedata;
                        cmd_read                <= host_avn_read;
                        sel_q                   <= dec_sel;
                        if (dec_hit) begin
                            // read has priority when both strobes are up
                            devices_avn_read  <= host_avn_read ? dec_sel : '0;
                            devices_avn_write <= host_avn_read ? '0 : dec_sel;
                            state             <= AVN_ACCESS;
`ifdef AVN_DECODER_TIMEOUT_EN
                            tmo_cnt           <= '0;
`endif
                        end else begin
                            host_avn_waitrequest <= 1'b0;
                            decode_error         <= 1'b1;
                            if (host_avn_read) begin
                                host_avn_readdata <= ERR_DATA_W;
                            end
                            state <= AVN_ERR;
                        end
                    end
                end
                AVN_ACCESS: begin
                    if (!dev_wait) begin
                        if (cmd_read) begin
                            host_avn_readdata <= dev_rdata;
                        end
                        devices_avn_read     <= '0;
                        devices_avn_write    <= '0;
                        host_avn_waitrequest <= 1'b0;
                        state                <= AVN_DONE;
                    end
`ifdef AVN_DECODER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        if (cmd_read) begin
                            host_avn_readdata <= ERR_DATA_W;
                        end
                        devices_avn_read     <= '0;
                        devices_avn_write    <= '0;
                        host_avn_waitrequest <= 1'b0;
                        decode_error         <= 1'b1;
                        state                <= AVN_ERR;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
`endif
                end
                AVN_DONE, AVN_ERR: begin
                    host_avn_waitrequest <= 1'b1;
                    state                <= AVN_IDLE;
                end
                default: begin
                    host_avn_waitrequest <= 1'b1;
                    state                <= AVN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_s_decoder.sv
// Scoreboard bench for avalon_s_decoder: stimulus pushes expected
// completions, a negedge monitor pops and compares them.
module tb_avalon_s_decoder;

    localparam int ND    = 2;
    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int TMO_W = 4;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  host_read = 1'b0;
    logic                  host_write = 1'b0;
    logic [AW-1:0]         host_addr = '0;
    logic [DW/8-1:0]       host_be = '0;
    logic [DW-1:0]         host_wdata = '0;
    logic [DW-1:0]         host_rdata;
    logic                  host_wait;
    logic [ND-1:0]         dev_rd;
    logic [ND-1:0]         dev_wr;
    logic [AW-1:0]         dev_addr;
    logic [DW/8-1:0]       dev_be;
    logic [DW-1:0]         dev_wdata;
    logic [ND-1:0][DW-1:0] dev_rdata = '0;
    logic [ND-1:0]         dev_wait = '1;
    logic                  dec_err;

    avalon_s_decoder #(
        .ND       (ND),
        .DW       (DW),
        .AW       (AW),
        .BASE     ({32'h0000_1000, 32'h0000_0000}),
        .MASK     ({32'h0000_F000, 32'h0000_F000}),
        .ERR_DATA (32'hDEAD_BEEF),
        .TMO_W    (TMO_W)
    ) dut (
        .clk                     (clk),
        .rst                     (rst),
        .host_avn_read           (host_read),
        .host_avn_write          (host_write),
        .host_avn_address        (host_addr),
        .host_avn_byte_enable    (host_be),
        .host_avn_writedata      (host_wdata),
        .host_avn_readdata       (host_rdata),
        .host_avn_waitrequest    (host_wait),
        .devices_avn_read        (dev_rd),
        .devices_avn_write       (dev_wr),
        .devices_avn_address     (dev_addr),
        .devices_avn_byte_enable (dev_be),
        .devices_avn_writedata   (dev_wdata),
        .devices_avn_readdata    (dev_rdata),
        .devices_avn_waitrequest (dev_wait),
        .decode_error            (dec_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
        logic [1:0]  rd_mask;
        logic [1:0]  wr_mask;
        int          strobe_cycles;
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wbe;
        int          issue;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int err_cycles = 0;
    int exp_err_cycles = 0;

    int          dev_waits[ND] = '{0, 0};
    int          dev_cnt[ND]   = '{0, 0};
    logic [31:0] cap_addr  = '0;
    logic [31:0] cap_wdata = '0;
    logic [3:0]  cap_be    = '0;

    logic [1:0] acc_rd_mask = '0;
    logic [1:0] acc_wr_mask = '0;
    int         acc_cycles  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] rdata, input logic err, input int lat,
                                input logic [1:0] rd_mask, input logic [1:0] wr_mask,
                                input int strobe_cycles, input logic [31:0] waddr,
                                input logic [31:0] wdata, input logic [3:0] wbe);
        exp_t e;
        e.rdata = rdata; e.err = err; e.lat = lat;
        e.rd_mask = rd_mask; e.wr_mask = wr_mask; e.strobe_cycles = strobe_cycles;
        e.waddr = waddr; e.wdata = wdata; e.wbe = wbe; e.issue = 0;
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Device model: each device holds waitrequest for dev_waits[i] strobed cycles
    always @(negedge clk) begin
        for (int i = 0; i < ND; i++) begin
            if (dev_rd[i] || dev_wr[i]) begin
                if (dev_cnt[i] >= dev_waits[i]) begin
                    dev_wait[i] = 1'b0;
                    if (dev_wr[i]) begin
                        cap_addr  = dev_addr;
                        cap_wdata = dev_wdata;
                        cap_be    = dev_be;
                    end
                end else begin
                    dev_wait[i] = 1'b1;
                end
                dev_cnt[i]++;
            end else begin
                dev_cnt[i]  = 0;
                dev_wait[i] = 1'b1;
            end
        end
    end

    // Monitor: accumulate device activity, compare on each host completion
    always @(negedge clk) begin
        if (!rst) begin
            acc_rd_mask = '0;
            acc_wr_mask = '0;
            acc_cycles  = 0;
        end else begin
            if (dec_err) err_cycles++;
            acc_rd_mask |= dev_rd;
            acc_wr_mask |= dev_wr;
            if ((dev_rd | dev_wr) != '0) acc_cycles++;
            if (!host_wait) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_completion", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("latency", 64'(cyc - mon_e.issue), 64'(mon_e.lat));
                    check("readdata", 64'(host_rdata), 64'(mon_e.rdata));
                    check("decode_error", 64'(dec_err), 64'(mon_e.err));
                    check("dev_read_mask", 64'(acc_rd_mask), 64'(mon_e.rd_mask));
                    check("dev_write_mask", 64'(acc_wr_mask), 64'(mon_e.wr_mask));
                    check("strobe_cycles", 64'(acc_cycles), 64'(mon_e.strobe_cycles));
                    if (mon_e.wr_mask != '0) begin
                        check("dev_waddr", 64'(cap_addr), 64'(mon_e.waddr));
                        check("dev_wdata", 64'(cap_wdata), 64'(mon_e.wdata));
                        check("dev_wbe", 64'(cap_be), 64'(mon_e.wbe));
                    end
                end
                acc_rd_mask = '0;
                acc_wr_mask = '0;
                acc_cycles  = 0;
            end
        end
    end

    task automatic xfer(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be, input exp_t e);
        bit done;
        @(posedge clk); #1;
        host_read  = rd;
        host_write = wr;
        host_addr  = addr;
        host_wdata = wdata;
        host_be    = be;
        e.issue    = cyc;
        exp_q.push_back(e);
        done = 0;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (!host_wait) done = 1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL xfer_wait: addr %0h never completed within 200 cycles", addr);
        end
        @(posedge clk); #1;
        host_read  = 1'b0;
        host_write = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_waitrequest", 64'(host_wait), 64'd1);
        check("rst_readdata", 64'(host_rdata), 64'd0);
        check("rst_strobes", 64'({dev_rd, dev_wr}), 64'd0);
        check("rst_address", 64'(dev_addr), 64'd0);
        check("rst_decode_error", 64'(dec_err), 64'd0);
        rst = 1'b1;

        // zero-wait read from device 1
        dev_rdata[1] = 32'hA5A5_0001; dev_waits[1] = 0;
        xfer(1, 0, 32'h0000_1004, 32'h0, 4'hF,
             mk(32'hA5A5_0001, 0, 2, 2'b10, 2'b00, 1, 0, 0, 0));

        // write to device 0 with three wait cycles; readdata holds
        dev_waits[0] = 3;
        xfer(0, 1, 32'h0000_0008, 32'h1234_5678, 4'b0011,
             mk(32'hA5A5_0001, 0, 5, 2'b00, 2'b01, 4, 32'h0000_0008, 32'h1234_5678, 4'b0011));

        // unmapped read
        xfer(1, 0, 32'h0000_8000, 32'h0, 4'hF,
             mk(32'hDEAD_BEEF, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        exp_err_cycles++;

        // read and write together: read wins
        dev_rdata[0] = 32'h0BAD_F00D; dev_waits[0] = 0;
        xfer(1, 1, 32'h0000_0000, 32'hFFFF_FFFF, 4'hF,
             mk(32'h0BAD_F00D, 0, 2, 2'b01, 2'b00, 1, 0, 0, 0));

        // unmapped write: discarded, readdata holds last value
        xfer(0, 1, 32'h0000_2000, 32'h5555_AAAA, 4'hF,
             mk(32'h0BAD_F00D, 1, 1, 2'b00, 2'b00, 0, 0, 0, 0));
        exp_err_cycles++;

        // top of device 1 window, one wait cycle
        dev_rdata[1] = 32'hC0DE_1FFC; dev_waits[1] = 1;
        xfer(1, 0, 32'h0000_1FFC, 32'h0, 4'hF,
             mk(32'hC0DE_1FFC, 0, 3, 2'b10, 2'b00, 2, 0, 0, 0));

        // upper address bits outside the mask alias onto device 0
        dev_rdata[0] = 32'h0001_0004;
        xfer(1, 0, 32'h0001_0004, 32'h0, 4'hF,
             mk(32'h0001_0004, 0, 2, 2'b01, 2'b00, 1, 0, 0, 0));

        // reset asserted mid-ACCESS with device 0 stuck
        dev_waits[0] = 1000;
        @(posedge clk); #1;
        host_read = 1'b1; host_addr = 32'h0000_0000;
        repeat (3) @(negedge clk);
        check("pre_rst_strobe", 64'(dev_rd), 64'b01);
        #1 rst = 1'b0;
        #1;
        check("rst_async_strobes", 64'({dev_rd, dev_wr}), 64'd0);
        check("rst_async_waitreq", 64'(host_wait), 64'd1);
        check("rst_async_readdata", 64'(host_rdata), 64'd0);
        host_read = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_idle_waitreq", 64'(host_wait), 64'd1);
        check("post_rst_idle_strobes", 64'({dev_rd, dev_wr}), 64'd0);

        // normal operation resumes from IDLE
        dev_rdata[1] = 32'h7777_0010; dev_waits[1] = 0;
        xfer(1, 0, 32'h0000_1010, 32'h0, 4'hF,
             mk(32'h7777_0010, 0, 2, 2'b10, 2'b00, 1, 0, 0, 0));

`ifdef AVN_DECODER_TIMEOUT_EN
        // stuck device aborts after 15 ACCESS cycles
        dev_waits[0] = 1000;
        xfer(1, 0, 32'h0000_0040, 32'h0, 4'hF,
             mk(32'hDEAD_BEEF, 1, 16, 2'b01, 2'b00, 15, 0, 0, 0));
        exp_err_cycles++;
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("decode_error_cycles", 64'(err_cycles), 64'(exp_err_cycles));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
